mem_stage_sram_ctrl: RTL
========================

Name: mem_stage_sram_ctrl

Overview:
- MEM-stage memory controller: the producer side of the MEM->WB pipeline interface.
- Takes EX->MEM pipeline outputs and runs each LDR/STR as two sequential 16-bit accesses to the off-chip SRAM.
- Holds the pipeline with `ready` low while an access is in flight.
- Delivers the assembled 32-bit load data plus pass-through control to the MEM->WB register.

Parameters:
- WAIT_CYCLES, 5, cycles each 16-bit half-access is held on the SRAM bus; legal range ≥1.
- ADDR_BASE, 1024, byte address subtracted from the ALU result before word mapping.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- wbEnIn  in  1  write-back enable from EX->MEM.
- memREnIn  in  1  load request.
- memWEnIn  in  1  store request.
- aluResIn  in  32  effective byte address, or ALU result for non-memory ops.
- valRmIn  in  32  store data.
- destIn  in  4  destination register.
- wbEnOut  out  1  to MEM->WB.
- memREnOut  out  1  to MEM->WB.
- aluResOut  out  32  to MEM->WB.
- memDataOut  out  32  load data to MEM->WB.
- destOut  out  4  to MEM->WB.
- ready  out  1  high = MEM stage may advance; low = stall all pipeline registers and the PC.
- sram_addr  out  18  SRAM half-word address.
- sram_wdata  out  16  SRAM write data.
- sram_oe  out  1  drive enable for sram_wdata onto the shared bus.
- sram_we_n  out  1  SRAM write strobe, active-low.
- sram_rdata  in  16  SRAM read data.

Behaviour:
- Pass-through: wbEnOut, memREnOut, aluResOut and destOut equal wbEnIn, memREnIn, aluResIn and destIn combinationally.
- Address map:
  - word = (aluResIn − ADDR_BASE) >> 2, truncated to 17 bits.
  - Low half address = {word, 0}; high half address = {word, 1}.
- Latching: address, valRmIn and op type (write if memWEnIn, else read) are latched on leaving IDLE. Later input changes do not affect the transaction.
- FSM states: IDLE, LOW, HIGH, DONE. A wait counter cnt is cleared on every state change.
  - IDLE: if memREnIn or memWEnIn → LOW. If both are asserted, treat as a write.
  - LOW: sram_addr = low address. When cnt == WAIT_CYCLES−1:
    - read: capture sram_rdata into rd_lo.
    - go to HIGH.
  - HIGH: sram_addr = high address. When cnt == WAIT_CYCLES−1:
    - read: memDataOut <= {sram_rdata, rd_lo}.
    - go to DONE.
  - DONE: unconditionally → IDLE.
- ready = (IDLE and no mem request) or DONE. ready is combinational from state and inputs.
- Stall length: a memory op holds ready low for exactly 2·WAIT_CYCLES+1 cycles. ready is high for one cycle in DONE, during which the MEM->WB register captures valid memDataOut.
- Write strobe, in LOW and HIGH for writes only, for all WAIT_CYCLES cycles:
  - sram_we_n = 0 and sram_oe = 1.
  - sram_wdata = valRm[15:0] in LOW, valRm[31:16] in HIGH.
  - Otherwise sram_we_n = 1, sram_oe = 0, sram_wdata = 0.
- sram_addr is 0 in IDLE and DONE.
- memDataOut updates only on reads and holds its value across stores and non-memory instructions.
- Back-to-back memory ops: the op following DONE is seen in IDLE on the next cycle and starts a new transaction. There is no idle-ready bubble beyond the DONE cycle.
- Reset values (rst low): state IDLE, cnt 0, rd_lo 0, memDataOut 0. The SRAM outputs take their IDLE values immediately and asynchronously: we_n 1, oe 0, addr 0, wdata 0.
- Reset mid-transaction aborts the transaction. A store aborted after LOW may leave only the low half written; this is accepted.

Test Plan:
- Idle pass-through: aluResIn=32'h0000_0042, destIn=4'h3, no mem enable → ready=1 every cycle, aluResOut=32'h42, destOut=3, sram_we_n=1, memDataOut stays 0.
- Load, WAIT_CYCLES=5, aluResIn=1032, SRAM model holds [4]=16'hBEEF and [5]=16'hDEAD:
  - sram_addr is 4 for 5 cycles, then 5 for 5 cycles.
  - ready is low 11 cycles, then high 1 cycle with memDataOut=32'hDEADBEEF.
- Store valRmIn=32'h12345678, aluResIn=1036:
  - sram_we_n low for 10 cycles.
  - addr 6 receives 16'h5678 and addr 7 receives 16'h1234.
  - memDataOut unchanged afterwards.
- Back-to-back loads at 1032 and 1040 → two 11-cycle stalls separated by a single ready cycle; memDataOut shows first word then second.
- Reset asserted in the 3rd HIGH cycle of a store → state returns to IDLE immediately, sram_we_n=1 asynchronously, memDataOut=0, ready=1 after release with no request.
- WAIT_CYCLES=1, load at 1024 → ready low exactly 3 cycles, addresses 0 then 1, each for 1 cycle.

Source files
------------

// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl
// MEM-stage controller that feeds the MEM->WB register. Each load or store
// is performed as two 16-bit SRAM accesses (low half, then high half). Each
// half is held on the SRAM bus for WAIT_CYCLES cycles. While a transaction
// is in flight, ready is held low to stall the pipeline.
//
// Ports
//   clk, rst                      clock; asynchronous active-low reset
//   wbEnIn, memREnIn, memWEnIn    EX->MEM control
//   aluResIn, valRmIn, destIn     EX->MEM address/result, store data, dest reg
//   wbEnOut, memREnOut,
//   aluResOut, destOut            combinational pass-through to MEM->WB
//   memDataOut                    assembled 32-bit load data (held until next load)
//   ready                         high = pipeline may advance
//   sram_addr, sram_wdata,
//   sram_oe, sram_we_n            SRAM half-word bus, write strobe active-low
//   sram_rdata                    SRAM read data
//
// state | meaning
// IDLE  | waiting for a load/store; ready high when no request is present
// LOW   | low half-word access at {word, 0}
// HIGH  | high half-word access at {word, 1}
// DONE  | one-cycle ready pulse; memDataOut is valid here for loads
module mem_stage_sram_ctrl #(
    parameter int          WAIT_CYCLES = 5,
    parameter logic [31:0] ADDR_BASE   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wbEnIn,
    input  logic        memREnIn,
    input  logic        memWEnIn,
    input  logic [31:0] aluResIn,
    input  logic [31:0] valRmIn,
    input  logic [3:0]  destIn,
    output logic        wbEnOut,
    output logic        memREnOut,
    output logic [31:0] aluResOut,
    output logic [31:0] memDataOut,
    output logic [3:0]  destOut,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_wdata,
    output logic        sram_oe,
    output logic        sram_we_n,
    input  logic [15:0] sram_rdata
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t        state, stateNext;
    logic [CW-1:0] cnt;
    logic [16:0]   addrWord;
    logic [31:0]   valRmLat;
    logic          opWrite;
    logic [15:0]   rdLo;
    logic          memReq;
    logic          lastCycle;
    logic [16:0]   wordIn;

    assign wbEnOut   = wbEnIn;
    assign memREnOut = memREnIn;
    assign aluResOut = aluResIn;
    assign destOut   = destIn;

    assign memReq    = memREnIn | memWEnIn;
    assign lastCycle = (cnt == CNT_LAST);
    // Byte address relative to the SRAM window, mapped to a 32-bit word index.
    assign wordIn    = 17'((aluResIn - ADDR_BASE) >> 2);

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (memReq)    stateNext = LOW;
            LOW:  if (lastCycle) stateNext = HIGH;
            HIGH: if (lastCycle) stateNext = DONE;
            DONE:                stateNext = IDLE;
            default:             stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            addrWord   <= '0;
            valRmLat   <= '0;
            opWrite    <= 1'b0;
            rdLo       <= '0;
            memDataOut <= '0;
        end else begin
            state <= stateNext;
            if (stateNext != state || state == IDLE || state == DONE) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end

            // Transaction parameters are frozen here so the pipeline inputs
            // may change freely while the access is in flight.
            if (state == IDLE && memReq) begin
                addrWord <= wordIn;
                valRmLat <= valRmIn;
                opWrite  <= memWEnIn;
            end

            if (state == LOW && lastCycle && !opWrite) begin
                rdLo <= sram_rdata;
            end
            if (state == HIGH && lastCycle && !opWrite) begin
                memDataOut <= {sram_rdata, rdLo};
            end
        end
    end

    always_comb begin
        sram_addr  = '0;
        sram_wdata = '0;
        sram_oe    = 1'b0;
        sram_we_n  = 1'b1;
        case (state)
            LOW: begin
                sram_addr = {addrWord, 1'b0};
                if (opWrite) begin
                    sram_we_n  = 1'b0;
                    sram_oe    = 1'b1;
                    sram_wdata = valRmLat[15:0];
                end
            end
            HIGH: begin
                sram_addr = {addrWord, 1'b1};
                if (opWrite) begin
                    sram_we_n  = 1'b0;
                    sram_oe    = 1'b1;
                    sram_wdata = valRmLat[31:16];
                end
            end
            default: ;
        endcase
    end

    assign ready = (state == IDLE && !memReq) || (state == DONE);

endmodule
